// File: rtl/fabric_port_pkg.sv
// Shared definitions for the fabric port: flit control-bit positions, packetizer
// states and the effective flit-count rule used by the packetizer.
package fabric_port_pkg;

    localparam int FP_PAYLOAD_WIDTH = 32;
    localparam int FP_FLIT_WIDTH    = FP_PAYLOAD_WIDTH + 3;

    // Control-bit positions decoded by the FIFO tail lookahead (default width)
    localparam int VALID_POS = FP_FLIT_WIDTH - 1;
    localparam int HEAD_POS  = FP_FLIT_WIDTH - 2;
    localparam int TAIL_POS  = FP_FLIT_WIDTH - 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } pkt_state_e;

    // Zero-length requests become one flit; oversize requests are clipped
    function automatic int eff_count(input int num_flits, input int max_flits);
        if (num_flits == 0) begin
            return 1;
        end else if (num_flits > max_flits) begin
            return max_flits;
        end else begin
            return num_flits;
        end
    endfunction

endpackage

// File: rtl/fabric_port_in_packetizer_flit_select.sv
// Combinational payload mux: picks chunk[sel] out of the latched packet.
module fabric_port_in_packetizer_flit_select #(
    parameter int PAYLOAD_WIDTH = 32,
    parameter int MAX_FLITS     = 4,
    parameter int IDX_W         = $clog2(MAX_FLITS)
) (
    input  logic [MAX_FLITS*PAYLOAD_WIDTH-1:0] pkt_data,
    input  logic [IDX_W-1:0]                   sel,
    output logic [PAYLOAD_WIDTH-1:0]           chunk
);

    logic [PAYLOAD_WIDTH-1:0] chunk_s;

    // Index-driven chunk selection; out-of-range indices yield zero
    always_comb begin
        chunk_s = '0;
        for (int k = 0; k < MAX_FLITS; k++) begin
            chunk_s = (sel == IDX_W'(k)) ? pkt_data[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] : chunk_s;
        end
    end

    assign chunk = chunk_s;

endmodule

// File: rtl/fabric_port_in_packetizer.sv
// Ingress packetizer: accepts a whole packet, emits one flit per cycle into the
// flit FIFO with valid/head/tail stamped, never writing while the FIFO is full.
module fabric_port_in_packetizer
    import fabric_port_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 32,
    parameter int MAX_FLITS     = 4,
    parameter int FLIT_WIDTH    = PAYLOAD_WIDTH + 3
) (
    input  logic                               clk,
    input  logic                               preset_full,
    input  logic [MAX_FLITS*PAYLOAD_WIDTH-1:0] i_data,
    input  logic [$clog2(MAX_FLITS+1)-1:0]     i_num_flits,
    input  logic                               i_valid,
    output logic                               o_ready,
    output logic [FLIT_WIDTH-1:0]              o_flit,
    output logic                               o_write_en,
    input  logic                               i_full,
    output logic                               o_busy
);

    localparam int IDX_W     = $clog2(MAX_FLITS);
    localparam int CNT_W     = $clog2(MAX_FLITS+1);
    localparam int VALID_BIT = VALID_POS + (FLIT_WIDTH - FP_FLIT_WIDTH);
    localparam int HEAD_BIT  = HEAD_POS + (FLIT_WIDTH - FP_FLIT_WIDTH);
    localparam int TAIL_BIT  = TAIL_POS + (FLIT_WIDTH - FP_FLIT_WIDTH);

    pkt_state_e                         state_r;
    pkt_state_e                         state_next_s;
    logic [IDX_W-1:0]                   idx_r;
    logic [CNT_W-1:0]                   n_r;
    logic [MAX_FLITS*PAYLOAD_WIDTH-1:0] pkt_r;
    logic [PAYLOAD_WIDTH-1:0]           chunk_s;
    logic                               last_s;
    logic                               write_s;
    logic                               ready_s;
    logic                               accept_s;

    fabric_port_in_packetizer_flit_select #(
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .MAX_FLITS     (MAX_FLITS),
        .IDX_W         (IDX_W)
    ) u_flit_select (
        .pkt_data (pkt_r),
        .sel      (idx_r),
        .chunk    (chunk_s)
    );

    assign last_s   = (CNT_W'(idx_r) == (n_r - CNT_W'(1)));
    assign write_s  = (state_r == SEND) & ~i_full;
    assign ready_s  = (state_r == IDLE) | (last_s & ~i_full);
    assign accept_s = i_valid & ready_s;

    // State register
    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: a tail write either chains straight into the next packet or idles
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (write_s & last_s & ~accept_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Packet register and flit index; everything holds while the FIFO is full
    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) begin
            pkt_r <= '0;
            n_r   <= '0;
            idx_r <= '0;
        end else if (accept_s) begin
            pkt_r <= i_data;
            n_r   <= CNT_W'(eff_count(int'(i_num_flits), MAX_FLITS));
            idx_r <= '0;
        end else if (write_s) begin
            idx_r <= idx_r + IDX_W'(1);
        end
    end

    // Outputs: flit built from registers only; strobes gated by the full flag
    always_comb begin
        o_flit     = '0;
        o_ready    = ready_s;
        o_write_en = write_s;
        o_busy     = (state_r == SEND);
        if (state_r == SEND) begin
            o_flit[VALID_BIT]           = 1'b1;
            o_flit[HEAD_BIT]            = (idx_r == '0);
            o_flit[TAIL_BIT]            = last_s;
            o_flit[PAYLOAD_WIDTH-1:0]   = chunk_s;
        end else begin
            o_flit = '0;
        end
    end

endmodule

// File: tb/tb_fabric_port_in_packetizer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-based model of the expected flit stream.
module tb_fabric_port_in_packetizer;

    localparam int PW = 32;
    localparam int MF = 4;
    localparam int FW = PW + 3;

    logic            clk;
    logic            preset_full;
    logic [MF*PW-1:0] i_data;
    logic [2:0]      i_num_flits;
    logic            i_valid;
    logic            o_ready;
    logic [FW-1:0]   o_flit;
    logic            o_write_en;
    logic            i_full;
    logic            o_busy;

    int checks;
    int failures;
    int writes_seen;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] last_flit;
    logic          last_we;

    fabric_port_in_packetizer #(
        .PAYLOAD_WIDTH (PW),
        .MAX_FLITS     (MF),
        .FLIT_WIDTH    (FW)
    ) dut (
        .clk         (clk),
        .preset_full (preset_full),
        .i_data      (i_data),
        .i_num_flits (i_num_flits),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_flit      (o_flit),
        .o_write_en  (o_write_en),
        .i_full      (i_full),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push the flits a packet should produce, derived directly from the packet rules
    task automatic model_accept(input logic [MF*PW-1:0] d, input int nf);
        int n;
        n = (nf == 0) ? 1 : ((nf > MF) ? MF : nf);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({1'b1, (k == 0), (k == n-1), d[k*PW +: PW]});
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model
    task automatic drive_cycle(input logic v, input logic [MF*PW-1:0] d, input int nf, input logic f);
        logic          e_ready;
        logic          e_we;
        logic [FW-1:0] e_flit;
        i_valid     = v;
        i_data      = d;
        i_num_flits = 3'(nf);
        i_full      = f;
        #2;
        e_we    = (exp_q.size() > 0) && !f;
        e_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && !f);
        e_flit  = (exp_q.size() > 0) ? exp_q[0] : '0;
        check_val("write_en", 64'(o_write_en), 64'(e_we));
        check_val("ready", 64'(o_ready), 64'(e_ready));
        check_val("busy", 64'(o_busy), 64'(exp_q.size() > 0));
        check_val("flit", 64'(o_flit), 64'(e_flit));
        last_we   = o_write_en;
        last_flit = o_flit;
        if (o_write_en) writes_seen++;
        if (e_we) void'(exp_q.pop_front());
        if (v && e_ready) model_accept(d, nf);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 64'(o_ready), 64'd1);
        check_val({tag, "_we"}, 64'(o_write_en), 64'd0);
        check_val({tag, "_flit"}, 64'(o_flit), 64'd0);
        check_val({tag, "_busy"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        logic [MF*PW-1:0] d;
        int w0;
        checks      = 0;
        failures    = 0;
        writes_seen = 0;
        preset_full = 1'b1;
        i_valid     = 1'b0;
        i_data      = '0;
        i_num_flits = 3'd0;
        i_full      = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        preset_full = 1'b0;

        // 3-flit packet A,B,C
        d = {32'h0, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        drive_cycle(1'b1, d, 3, 1'b0);
        drive_cycle(1'b0, '0, 0, 1'b0);
        check_val("abc_head", 64'(last_flit), 64'({3'b110, 32'hAAAA_0001}));
        drive_cycle(1'b0, '0, 0, 1'b0);
        drive_cycle(1'b0, '0, 0, 1'b0);
        check_val("abc_tail", 64'(last_flit), 64'({3'b101, 32'hCCCC_0003}));
        drive_cycle(1'b0, '0, 0, 1'b0);

        // Zero-count packet becomes a single head+tail flit
        d = {96'h0, 32'hDEAD_BEEF};
        drive_cycle(1'b1, d, 0, 1'b0);
        drive_cycle(1'b0, '0, 0, 1'b0);
        check_val("one_flit_we", 64'(last_we), 64'd1);
        check_val("one_flit", 64'(last_flit), 64'({3'b111, 32'hDEAD_BEEF}));
        drive_cycle(1'b0, '0, 0, 1'b0);

        // Oversize count clipped to MAX_FLITS
        w0 = writes_seen;
        d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        drive_cycle(1'b1, d, 7, 1'b0);
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 0, 1'b0);
        check_val("clip_count", 64'(writes_seen - w0), 64'd4);

        // Full held for 3 cycles during flit 2
        w0 = writes_seen;
        d = {32'h0, 32'h0, 32'h5A5A_0002, 32'h5A5A_0001};
        drive_cycle(1'b1, d, 2, 1'b0);
        drive_cycle(1'b0, '0, 0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, '1, 3, 1'b1);
        drive_cycle(1'b0, '0, 0, 1'b0);
        check_val("full_resume", 64'(last_flit), 64'({3'b101, 32'h5A5A_0002}));
        drive_cycle(1'b0, '0, 0, 1'b0);
        check_val("full_count", 64'(writes_seen - w0), 64'd2);

        // Back-to-back 2-flit packets
        w0 = writes_seen;
        d = {64'h0, 32'hB2B2_0002, 32'hB1B1_0001};
        drive_cycle(1'b1, d, 2, 1'b0);
        drive_cycle(1'b1, {64'h0, 32'hC2C2_0002, 32'hC1C1_0001}, 2, 1'b0);
        drive_cycle(1'b1, {64'h0, 32'hC2C2_0002, 32'hC1C1_0001}, 2, 1'b0);
        drive_cycle(1'b0, '0, 0, 1'b0);
        check_val("b2b_head2", 64'(last_flit), 64'({3'b110, 32'hC1C1_0001}));
        drive_cycle(1'b0, '0, 0, 1'b0);
        check_val("b2b_count", 64'(writes_seen - w0), 64'd4);
        drive_cycle(1'b0, '0, 0, 1'b0);

        // Reset after the head of a 4-flit packet
        d = {32'hD4, 32'hD3, 32'hD2, 32'hD1};
        drive_cycle(1'b1, d, 4, 1'b0);
        drive_cycle(1'b0, '0, 0, 1'b0);
        i_valid = 1'b0;
        preset_full = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        #1;
        preset_full = 1'b0;
        d = {32'hE4, 32'hE3, 32'hE2, 32'hE1};
        drive_cycle(1'b1, d, 2, 1'b0);
        drive_cycle(1'b0, '0, 0, 1'b0);
        check_val("post_reset_head", 64'(last_flit), 64'({3'b110, 32'hE1}));
        drive_cycle(1'b0, '0, 0, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            drive_cycle(1'($urandom_range(0, 1)), d, int'($urandom_range(0, 7)),
                        ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, 0, 1'b0);
        check_val("drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
